// File: rtl/tuner_phy_pkg.sv
// Purpose: shared types for the ring tuner PHY control blocks.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package tuner_phy_pkg;

    // Sequencer states of the tuner code arbiter.
    typedef enum logic [1:0] {
        INIT   = 2'd0,
        TUNE   = 2'd1,
        SYNC   = 2'd2,
        COMMIT = 2'd3
    } tuner_phy_ctrl_arb_state_e;

    // Controller channel identifiers.
    typedef enum logic {
        CH_SEARCH = 1'b0,
        CH_LOCK   = 1'b1
    } tuner_ctrl_ch_e;

    // Error status reported with each tune response.
    typedef enum logic {
        ERROR_NONE    = 1'b0,
        ERROR_TIMEOUT = 1'b1
    } tuner_phy_error_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tuner_phy_rr_arb2.sv
// Purpose: 2-way round-robin winner select between search and lock requests.
// Latency: winner is combinational; last_grant updates on the accept edge.
// Backpressure: none; the caller qualifies the winner with its own ready/accept.
// Ports: search_req/lock_req in, accept in (a winner was taken this cycle),
//        search_win/lock_win one-hot winner out, win_ch winner channel out.
module tuner_phy_rr_arb2
    import tuner_phy_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           search_req,
    input  logic           lock_req,
    input  logic           accept,
    output logic           search_win,
    output logic           lock_win,
    output tuner_ctrl_ch_e win_ch
);

    tuner_ctrl_ch_e last_grant;

    always_comb begin
        search_win = 1'b0;
        lock_win   = 1'b0;
        if (search_req && lock_req) begin
            // Tie: the channel not served last goes next.
            search_win = (last_grant == CH_LOCK);
            lock_win   = (last_grant == CH_SEARCH);
        end else begin
            search_win = search_req;
            lock_win   = lock_req;
        end
        win_ch = lock_win ? CH_LOCK : CH_SEARCH;
    end

    // Reset to LOCK so the first tie after reset goes to search.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= CH_LOCK;
        end else if (accept) begin
            last_grant <= win_ch;
        end
    end

endmodule

// File: rtl/tuner_phy_ctrl_arb.sv
// Purpose: shares the ring tuner DAC between search and lock controllers; per
//          transaction: grant, drive code, settle, fetch one power sample, respond.
// Latency: accept->rsp_valid = SETTLE_CYCLES+2 (+ detector wait); ready again one cycle later.
// Backpressure: req_ready only in INIT for the winner; responses are one-cycle pulses with no backpressure.
// Ports: {search,lock}_req_{valid,code,ready}, {search,lock}_rsp_{valid,pwr,err},
//        tuner_code / pwr_rd_req / pwr_rd_valid / pwr_rd_data to the front end,
//        grant_ch and arb_state for observation.
module tuner_phy_ctrl_arb
    import tuner_phy_pkg::*;
#(
    parameter int DAC_WIDTH      = 8,
    parameter int ADC_WIDTH      = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      search_req_valid,
    input  logic [DAC_WIDTH-1:0]      search_req_code,
    output logic                      search_req_ready,
    output logic                      search_rsp_valid,
    output logic [ADC_WIDTH-1:0]      search_rsp_pwr,
    output logic                      search_rsp_err,
    input  logic                      lock_req_valid,
    input  logic [DAC_WIDTH-1:0]      lock_req_code,
    output logic                      lock_req_ready,
    output logic                      lock_rsp_valid,
    output logic [ADC_WIDTH-1:0]      lock_rsp_pwr,
    output logic                      lock_rsp_err,
    output logic [DAC_WIDTH-1:0]      tuner_code,
    output logic                      pwr_rd_req,
    input  logic                      pwr_rd_valid,
    input  logic [ADC_WIDTH-1:0]      pwr_rd_data,
    output tuner_ctrl_ch_e            grant_ch,
    output tuner_phy_ctrl_arb_state_e arb_state
);

    // One down-counter serves both the settle interval and the sample timeout.
    localparam int CNT_MAX = max2(SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES - 1);

    tuner_phy_ctrl_arb_state_e state, state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic                      cnt_zero;
    logic                      search_win, lock_win, accept;
    tuner_ctrl_ch_e            win_ch;
    logic                      sync_done;
    tuner_phy_error_state_e    sync_err;
    logic [ADC_WIDTH-1:0]      sync_pwr;

    tuner_phy_rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .rst        (rst),
        .search_req (search_req_valid),
        .lock_req   (lock_req_valid),
        .accept     (accept),
        .search_win (search_win),
        .lock_win   (lock_win),
        .win_ch     (win_ch)
    );

    assign search_req_ready = (state == INIT) && search_win;
    assign lock_req_ready   = (state == INIT) && lock_win;
    assign accept           = (state == INIT) && (search_req_valid || lock_req_valid);
    assign cnt_zero         = (cnt == '0);
    assign arb_state        = state;

    // A sample on the last SYNC cycle wins over the timeout.
    always_comb begin
        sync_done = pwr_rd_valid || cnt_zero;
        sync_err  = pwr_rd_valid ? ERROR_NONE : ERROR_TIMEOUT;
        sync_pwr  = pwr_rd_valid ? pwr_rd_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (accept)    state_nxt = TUNE;
            TUNE:    if (cnt_zero)  state_nxt = SYNC;
            SYNC:    if (sync_done) state_nxt = COMMIT;
            COMMIT:                 state_nxt = INIT;
            default:                state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt              <= '0;
            tuner_code       <= '0;
            grant_ch         <= CH_SEARCH;
            pwr_rd_req       <= 1'b0;
            search_rsp_valid <= 1'b0;
            search_rsp_pwr   <= '0;
            search_rsp_err   <= 1'b0;
            lock_rsp_valid   <= 1'b0;
            lock_rsp_pwr     <= '0;
            lock_rsp_err     <= 1'b0;
        end else begin
            pwr_rd_req       <= 1'b0;
            search_rsp_valid <= 1'b0;
            lock_rsp_valid   <= 1'b0;
            case (state)
                INIT: begin
                    if (accept) begin
                        grant_ch   <= win_ch;
                        tuner_code <= lock_win ? lock_req_code : search_req_code;
                        cnt        <= SETTLE_LD;
                    end
                end
                TUNE: begin
                    if (cnt_zero) begin
                        cnt        <= TIMEOUT_LD;
                        pwr_rd_req <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SYNC: begin
                    if (sync_done) begin
                        if (grant_ch == CH_LOCK) begin
                            lock_rsp_valid <= 1'b1;
                            lock_rsp_pwr   <= sync_pwr;
                            lock_rsp_err   <= (sync_err == ERROR_TIMEOUT);
                        end else begin
                            search_rsp_valid <= 1'b1;
                            search_rsp_pwr   <= sync_pwr;
                            search_rsp_err   <= (sync_err == ERROR_TIMEOUT);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tuner_phy_ctrl_arb.sv
module tb_tuner_phy_ctrl_arb;
    import tuner_phy_pkg::*;

    localparam int SETTLE = 4;
    localparam int TMO    = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       search_req_valid = 1'b0;
    logic [7:0] search_req_code  = 8'h00;
    logic       search_req_ready;
    logic       search_rsp_valid;
    logic [7:0] search_rsp_pwr;
    logic       search_rsp_err;
    logic       lock_req_valid = 1'b0;
    logic [7:0] lock_req_code  = 8'h00;
    logic       lock_req_ready;
    logic       lock_rsp_valid;
    logic [7:0] lock_rsp_pwr;
    logic       lock_rsp_err;
    logic [7:0] tuner_code;
    logic       pwr_rd_req;
    logic       pwr_rd_valid = 1'b0;
    logic [7:0] pwr_rd_data  = 8'h00;
    tuner_ctrl_ch_e            grant_ch;
    tuner_phy_ctrl_arb_state_e arb_state;

    tuner_phy_ctrl_arb #(
        .DAC_WIDTH(8), .ADC_WIDTH(8), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .search_req_valid(search_req_valid), .search_req_code(search_req_code),
        .search_req_ready(search_req_ready), .search_rsp_valid(search_rsp_valid),
        .search_rsp_pwr(search_rsp_pwr), .search_rsp_err(search_rsp_err),
        .lock_req_valid(lock_req_valid), .lock_req_code(lock_req_code),
        .lock_req_ready(lock_req_ready), .lock_rsp_valid(lock_rsp_valid),
        .lock_rsp_pwr(lock_rsp_pwr), .lock_rsp_err(lock_rsp_err),
        .tuner_code(tuner_code), .pwr_rd_req(pwr_rd_req),
        .pwr_rd_valid(pwr_rd_valid), .pwr_rd_data(pwr_rd_data),
        .grant_ch(grant_ch), .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         ch;
        logic [7:0] pwr;
        bit         err;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (search_rsp_valid || lock_rsp_valid) begin
            check("rsp_one_hot", {31'd0, search_rsp_valid && lock_rsp_valid}, 32'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp @cycle %0d: got a response, required none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_ch", {31'd0, lock_rsp_valid}, {31'd0, mon_e.ch});
                check("rsp_pwr", lock_rsp_valid ? lock_rsp_pwr : search_rsp_pwr, mon_e.pwr);
                check("rsp_err", lock_rsp_valid ? lock_rsp_err : search_rsp_err, mon_e.err);
                check("rsp_cycle", cyc, mon_e.at);
            end
        end
    end

    // vld_off: cycle (relative to accept) of the detector sample, <0 for none.
    // junk: also pulse the detector during INIT (accept cycle) and TUNE.
    task automatic run_txn(input bit ch, input logic [7:0] code, input int vld_off,
                           input logic [7:0] data, input bit junk);
        int   acc;
        exp_t x;
        tick();
        if (ch) begin lock_req_valid = 1'b1; lock_req_code = code; end
        else begin search_req_valid = 1'b1; search_req_code = code; end
        if (junk) begin pwr_rd_valid = 1'b1; pwr_rd_data = 8'hEE; end
        @(negedge clk);
        check("req_ready", ch ? lock_req_ready : search_req_ready, 1);
        acc = cyc;
        x.ch = ch;
        if (vld_off < 0) begin
            x.pwr = 8'h00; x.err = 1'b1; x.at = acc + SETTLE + 1 + TMO;
        end else begin
            x.pwr = data; x.err = 1'b0; x.at = acc + vld_off + 1;
        end
        sb.push_back(x);
        tick();
        search_req_valid = 1'b0;
        lock_req_valid   = 1'b0;
        pwr_rd_valid     = 1'b0;
        @(negedge clk);
        check("tuner_code_first_tune", tuner_code, code);
        check("grant_ch", grant_ch, ch);
        check("ready_in_tune", {search_req_ready, lock_req_ready}, 0);
        while (cyc < x.at + 1) begin
            tick();
            pwr_rd_valid = (vld_off >= 0 && cyc == acc + vld_off) || (junk && cyc == acc + 2);
            pwr_rd_data  = (junk && cyc == acc + 2) ? 8'hEE : data;
            @(negedge clk);
            if (cyc == acc + SETTLE + 1) begin
                check("pwr_rd_req_entry", pwr_rd_req, 1);
                check("state_sync_entry", arb_state, SYNC);
            end
            if (cyc == acc + SETTLE + 2) check("pwr_rd_req_once", pwr_rd_req, 0);
        end
        pwr_rd_valid = 1'b0;
        check("state_init_after", arb_state, INIT);
    endtask

    initial begin
        int acc;
        exp_t x;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", arb_state, INIT);
        check("rst_grant", grant_ch, CH_SEARCH);
        check("rst_code", tuner_code, 0);
        check("rst_outs", {search_req_ready, lock_req_ready, search_rsp_valid, lock_rsp_valid, pwr_rd_req}, 0);
        check("rst_data", {search_rsp_pwr, search_rsp_err, lock_rsp_pwr, lock_rsp_err}, 0);
        rst = 1'b0;

        run_txn(1'b0, 8'h5A, 7, 8'h33, 1'b0);                    // basic latency
        run_txn(1'b0, 8'hC3, 6, 8'h10, 1'b1);                    // pulses outside SYNC ignored
        run_txn(1'b1, 8'h81, -1, 8'h00, 1'b0);                   // detector silent -> timeout
        run_txn(1'b0, 8'h07, SETTLE + TMO, 8'h5C, 1'b0);         // sample on last SYNC cycle

        // Reset while in SYNC drops the transaction.
        tick();
        lock_req_valid = 1'b1; lock_req_code = 8'h77;
        @(negedge clk);
        acc = cyc;
        tick();
        lock_req_valid = 1'b0;
        while (cyc < acc + SETTLE + 2) tick();
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_sync", arb_state, SYNC);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_state", arb_state, INIT);
        check("mid_rst_code", tuner_code, 0);
        check("mid_rst_norsp", lock_rsp_valid, 0);
        repeat (5) tick();
        run_txn(1'b1, 8'h42, 9, 8'h24, 1'b0);                    // fresh request after reset

        // Both held: round robin search, lock, search.
        tick();
        search_req_valid = 1'b1; search_req_code = 8'h11;
        lock_req_valid   = 1'b1; lock_req_code   = 8'h22;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("tie_search_ready", search_req_ready, (i != 1));
            check("tie_lock_ready", lock_req_ready, (i == 1));
            acc = cyc;
            x.ch = (i == 1); x.pwr = 8'h80 + 8'(i); x.err = 1'b0; x.at = acc + SETTLE + 2;
            sb.push_back(x);
            tick();
            @(negedge clk);
            check("tie_code", tuner_code, (i == 1) ? 8'h22 : 8'h11);
            check("tie_ready_busy", {search_req_ready, lock_req_ready}, 0);
            while (cyc < acc + SETTLE + 1) tick();
            pwr_rd_valid = 1'b1; pwr_rd_data = 8'h80 + 8'(i);
            tick();
            pwr_rd_valid = 1'b0;
            while (cyc < acc + SETTLE + 3) tick();
            if (i == 2) begin search_req_valid = 1'b0; lock_req_valid = 1'b0; end
        end

        repeat (5) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tuner_phy_ctrl_arb.md
# tuner_phy_ctrl_arb

Owns the ring tuner DAC code and shares it between the search and lock controllers. Each transaction runs in order: grant one controller's code request, drive the code to the tuner, wait a settle interval, fetch one power sample from the power detector, then return that sample to the requesting controller. It sits between the two controllers (upstream) and the tuner DAC and power-detector front end (downstream). Its sequencer uses the shared `tuner_phy_ctrl_arb_state_e` states.

## Interface
Parameters:
- `DAC_WIDTH`, 8, tuner code width
- `ADC_WIDTH`, 8, power sample width
- `SETTLE_CYCLES`, 4, cycles spent in TUNE; must be ≥1
- `TIMEOUT_CYCLES`, 64, maximum SYNC cycles spent waiting for a power sample; must be ≥1

Ports (x ∈ {search, lock}):
- `clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `x_req_valid`  in  1  controller x requests a tune
- `x_req_code`  in  DAC_WIDTH  requested tuner code
- `x_req_ready`  out  1  request accepted when valid & ready
- `x_rsp_valid`  out  1  one-cycle response pulse; no backpressure
- `x_rsp_pwr`  out  ADC_WIDTH  sampled power; 0 on error
- `x_rsp_err`  out  1  qualifies rsp_valid; 1 = detector timeout
- `tuner_code`  out  DAC_WIDTH  registered DAC code
- `pwr_rd_req`  out  1  one-cycle power read request
- `pwr_rd_valid`  in  1  detector sample valid
- `pwr_rd_data`  in  ADC_WIDTH  detector sample
- `grant_ch`  out  1  `tuner_ctrl_ch_e` of the current or last owner
- `arb_state`  out  2  `tuner_phy_ctrl_arb_state_e`

## Operation
- **INIT**: idle state.
  - Computes the winner among valid requests and raises ready only for the winner.
  - One requester valid: that requester wins.
  - Both valid: the channel opposite `last_grant` wins (round-robin).
  - On accept: latch the code, set `grant_ch` and `last_grant`, go to TUNE.
- **TUNE**:
  - `tuner_code` takes the latched code on the first TUNE cycle.
  - Stays exactly SETTLE_CYCLES cycles, then goes to SYNC.
- **SYNC**:
  - `pwr_rd_req`=1 on the entry cycle only.
  - `pwr_rd_valid` is accepted on any SYNC cycle, including the entry cycle. The data is captured and the block goes to COMMIT with err=0.
  - Timeout fires after TIMEOUT_CYCLES SYNC cycles with no valid: go to COMMIT with err=1 and pwr=0.
  - A valid arriving on the final SYNC cycle takes priority over the timeout.
- **COMMIT**: for exactly one cycle, the granted channel gets `rsp_valid`=1 with pwr/err; then return to INIT.
- `pwr_rd_valid` outside SYNC is ignored.
- Both ready outputs are 0 outside INIT.
- `tuner_code` holds its last value between transactions.
- `rsp_pwr`/`rsp_err` hold their values after the pulse; they are only meaningful while `rsp_valid`=1.

## Timing
- Reset values:
  - state INIT; `last_grant`=CH_LOCK, so the first tie goes to search.
  - `grant_ch`=CH_SEARCH.
  - `tuner_code`=0.
  - All ready, valid and `pwr_rd_req` outputs 0; all rsp data 0.
- Reset mid-transaction: the in-flight transaction is dropped, no response is issued, and `tuner_code` returns to 0 on the next edge.
- Ready is combinational from valid and state; all other outputs are registered.
- Latency with SETTLE=4, accept at cycle 0, detector valid at cycle 7:
  - TUNE at cycles 1–4.
  - SYNC entry and `pwr_rd_req` at cycle 5.
  - `rsp_valid` at cycle 8.
  - INIT and ready again at cycle 9.
- Minimum transaction length is SETTLE_CYCLES+3 cycles, from accept to the next ready.

## Structure
- `tuner_phy_pkg` already supplies `tuner_phy_ctrl_arb_state_e` and `tuner_ctrl_ch_e`; reuse them unchanged.
- Add `ERROR_TIMEOUT` reporting through the existing `tuner_phy_error_state_e` where it is exposed upward.
- Sub-module `tuner_phy_rr_arb2`: a combinational 2-way round-robin winner select with a registered `last_grant` update on accept.
- Settle and timeout share one down-counter sized to $clog2 of max(SETTLE_CYCLES, TIMEOUT_CYCLES)+1.

## Test plan
- Reset, then a single search request with code 0x5A.
  - `tuner_code`=0x5A at cycle 1.
  - `pwr_rd_req` at cycle 5.
  - Detector returns 0x33 at cycle 7 → `search_rsp_valid`=1, pwr=0x33, err=0 at cycle 8.
- Search and lock valid simultaneously, both held, three times → grants go search, lock, search.
  - The loser's ready stays 0 throughout.
  - Each response goes only to its owner.
- Detector silent, TIMEOUT=64 → `lock_rsp_valid`=1, err=1, pwr=0 exactly 64 cycles after SYNC entry; back in INIT the next cycle.
- `pwr_rd_valid` pulsed during TUNE and INIT → ignored; the later in-SYNC sample 0x10 is returned.
- `rst` asserted in SYNC → next cycle state INIT, `tuner_code`=0, no rsp pulse; a fresh request then completes normally.
- Detector valid on the same cycle the timeout would fire → err=0 and sample returned.
